config_tile_ctrl: RTL and testbench

CONFIG_TILE_CTRL -- requirements
Module: config_tile

---
 rtl/config_tile_ctrl.sv | 116 +++++++++++
 tb/tb_config_tile_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_tile_ctrl.sv
// Configuration tile controller.
// Two serial shift registers (soft and hard) are loaded one bit per clock.
// A capture request copies the low bits of one register into either the
// combinational or the memory config word. The target alternates on every
// capture, starting with the combinational word.
// The soft register's MSB is daisy-chained to the next tile through shift_out.
module config_tile_ctrl #(
    parameter int COMB_W = 5,
    parameter int MEM_W  = 7,
    parameter int SR_LEN = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_soft,
    input  logic              set_hard,
    input  logic              shift_in_soft,
    input  logic              shift_in_hard,
    output logic              shift_out,
    output logic [COMB_W-1:0] comb_config,
    output logic [MEM_W-1:0]  mem_config
);

    // Phase encoding: which config word the next capture writes.
    typedef enum logic [0:0] {
        PH_COMB = 1'b0,
        PH_MEM  = 1'b1
    } phase_t;

    phase_t              phase_r;
    phase_t              phase_nxt_s;
    logic [SR_LEN-1:0]   soft_r;
    logic [SR_LEN-1:0]   hard_r;
    logic [COMB_W-1:0]   comb_r;
    logic [MEM_W-1:0]    mem_r;

    logic                hard_cap_s;
    logic                soft_cap_s;
    logic                capture_s;
    logic [SR_LEN-1:0]   sel_word_s;
    logic [SR_LEN-1:0]   soft_nxt_s;
    logic [SR_LEN-1:0]   hard_nxt_s;
    logic [COMB_W-1:0]   comb_nxt_s;
    logic [MEM_W-1:0]    mem_nxt_s;

    // A hard request always wins; a soft request only acts when hard is idle.
    assign hard_cap_s = set_hard;
    assign soft_cap_s = set_soft & ~set_hard;
    assign capture_s  = hard_cap_s | soft_cap_s;

    // State register: all tile state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= PH_COMB;
            soft_r  <= {SR_LEN{1'b0}};
            hard_r  <= {SR_LEN{1'b0}};
            comb_r  <= {COMB_W{1'b0}};
            mem_r   <= {MEM_W{1'b0}};
        end else begin
            phase_r <= phase_nxt_s;
            soft_r  <= soft_nxt_s;
            hard_r  <= hard_nxt_s;
            comb_r  <= comb_nxt_s;
            mem_r   <= mem_nxt_s;
        end
    end

    // Next phase: every accepted capture flips the comb/mem target.
    always_comb begin
        phase_nxt_s = phase_r;
        if (capture_s) begin
            case (phase_r)
                PH_COMB: phase_nxt_s = PH_MEM;
                PH_MEM:  phase_nxt_s = PH_COMB;
                default: phase_nxt_s = PH_COMB;
            endcase
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Datapath: shift or clear each register, and load the selected config word.
    always_comb begin
        sel_word_s = {SR_LEN{1'b0}};
        soft_nxt_s = {soft_r[SR_LEN-2:0], shift_in_soft};
        hard_nxt_s = {hard_r[SR_LEN-2:0], shift_in_hard};
        comb_nxt_s = comb_r;
        mem_nxt_s  = mem_r;

        if (hard_cap_s) begin
            sel_word_s = hard_r;
            hard_nxt_s = {SR_LEN{1'b0}};
        end else if (soft_cap_s) begin
            sel_word_s = soft_r;
            soft_nxt_s = {SR_LEN{1'b0}};
        end else begin
            sel_word_s = {SR_LEN{1'b0}};
        end

        if (capture_s) begin
            case (phase_r)
                PH_COMB: comb_nxt_s = sel_word_s[COMB_W-1:0];
                PH_MEM:  mem_nxt_s  = sel_word_s[MEM_W-1:0];
                default: comb_nxt_s = comb_r;
            endcase
        end else begin
            comb_nxt_s = comb_r;
            mem_nxt_s  = mem_r;
        end
    end

    // Outputs are taken straight from registers: no input-to-output path.
    assign shift_out   = soft_r[SR_LEN-1];
    assign comb_config = comb_r;
    assign mem_config  = mem_r;

endmodule

// File: tb/tb_config_tile_ctrl.sv
// Self-checking bench for config_tile_ctrl.
// A reference model keeps each shift register as a queue of the last SR_LEN
// bits, and picks the capture target from how many captures it has counted.
// For each cycle the driver pushes the expected post-edge outputs. A monitor
// pops them one clock edge later and compares. Directed checks cover the
// documented load sequences.
module tb_config_tile_ctrl;

    localparam int COMB_W = 5;
    localparam int MEM_W  = 7;
    localparam int SR_LEN = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              set_soft = 1'b0;
    logic              set_hard = 1'b0;
    logic              shift_in_soft = 1'b0;
    logic              shift_in_hard = 1'b0;
    logic              shift_out;
    logic [COMB_W-1:0] comb_config;
    logic [MEM_W-1:0]  mem_config;

    config_tile_ctrl #(.COMB_W(COMB_W), .MEM_W(MEM_W), .SR_LEN(SR_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .set_soft      (set_soft),
        .set_hard      (set_hard),
        .shift_in_soft (shift_in_soft),
        .shift_in_hard (shift_in_hard),
        .shift_out     (shift_out),
        .comb_config   (comb_config),
        .mem_config    (mem_config)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              so;
        logic [COMB_W-1:0] comb;
        logic [MEM_W-1:0]  mem;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic              m_soft[$];
    logic              m_hard[$];
    logic [COMB_W-1:0] m_comb;
    logic [MEM_W-1:0]  m_mem;
    int                m_caps;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void zero_fill(inout logic q[$]);
        q = {};
        for (int i = 0; i < SR_LEN; i++) q.push_back(1'b0);
    endfunction

    // Word view of a history queue: the newest bit goes to bit 0.
    function automatic logic [SR_LEN-1:0] recent_word(input logic q[$]);
        logic [SR_LEN-1:0] w;
        w = '0;
        for (int i = 0; i < SR_LEN; i++) w[i] = q[SR_LEN-1-i];
        return w;
    endfunction

    function automatic void push_bit(inout logic q[$], input logic b);
        q.push_back(b);
        void'(q.pop_front());
    endfunction

    function automatic void model_capture(input logic [SR_LEN-1:0] w);
        if (m_caps % 2 == 0) m_comb = w[COMB_W-1:0];
        else                 m_mem  = w[MEM_W-1:0];
        m_caps++;
    endfunction

    // Drive one clock cycle, update the model, and queue the expected result.
    task automatic cycle(input logic r, input logic ss, input logic sh,
                         input logic is, input logic ih);
        exp_t e;
        rst = r; set_soft = ss; set_hard = sh;
        shift_in_soft = is; shift_in_hard = ih;
        if (r) begin
            zero_fill(m_soft); zero_fill(m_hard);
            m_comb = '0; m_mem = '0; m_caps = 0;
        end else if (sh) begin
            model_capture(recent_word(m_hard));
            zero_fill(m_hard);
            push_bit(m_soft, is);
        end else if (ss) begin
            model_capture(recent_word(m_soft));
            zero_fill(m_soft);
            push_bit(m_hard, ih);
        end else begin
            push_bit(m_soft, is);
            push_bit(m_hard, ih);
        end
        e.so = m_soft[0]; e.comb = m_comb; e.mem = m_mem;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every edge, compare the DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_shift_out", {31'd0, shift_out}, {31'd0, e.so});
                chk("sb_comb", {27'd0, comb_config}, {27'd0, e.comb});
                chk("sb_mem", {25'd0, mem_config}, {25'd0, e.mem});
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        logic b[14];
        logic c[7];
        logic d[5];
        logic [6:0] seq30;
        logic [4:0] seq29;
        logic [6:0] w7;
        logic [4:0] w5;
        zero_fill(m_soft); zero_fill(m_hard);
        m_comb = '0; m_mem = '0; m_caps = 0;
        seq29 = 5'b10110;
        seq30 = 7'b1100101;

        // Reset with both capture requests active
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_comb", {27'd0, comb_config}, 32'd0);
        chk("rst_mem", {25'd0, mem_config}, 32'd0);
        chk("rst_shift_out", {31'd0, shift_out}, 32'd0);

        // 14-bit daisy chain, no capture
        for (int k = 0; k < 14; k++) begin
            b[k] = 1'($urandom_range(0, 1));
            if (k < 7) chk("chain_zero", {31'd0, shift_out}, 32'd0);
            else       chk("chain_bit", {31'd0, shift_out}, {31'd0, b[k-7]});
            chk("chain_comb", {27'd0, comb_config}, 32'd0);
            chk("chain_mem", {25'd0, mem_config}, 32'd0);
            cycle(1'b0, 1'b0, 1'b0, b[k], 1'b0);
        end

        // Load the comb word with 1,0,1,1,0
        for (int i = 4; i >= 0; i--) cycle(1'b0, 1'b0, 1'b0, seq29[i], 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("soft_comb", {27'd0, comb_config}, {27'd0, seq29});
        chk("soft_comb_mem", {25'd0, mem_config}, 32'd0);

        // Load the mem word; shift_out stays 0 while S refills
        for (int i = 6; i >= 0; i--) begin
            chk("post_cap_zero", {31'd0, shift_out}, 32'd0);
            cycle(1'b0, 1'b0, 1'b0, seq30[i], 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("soft_mem", {25'd0, mem_config}, {25'd0, seq30});
        chk("soft_mem_comb", {27'd0, comb_config}, {27'd0, seq29});

        // Hard capture wins over a simultaneous soft request
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        chk("hard_comb", {27'd0, comb_config}, 32'h1f);
        chk("hard_mem", {25'd0, mem_config}, {25'd0, seq30});

        // Phase toggled once, so the next soft capture goes to mem
        for (int i = 0; i < 7; i++) begin
            c[i] = 1'($urandom_range(0, 1));
            cycle(1'b0, 1'b0, 1'b0, c[i], 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) w7[6-i] = c[i];
        chk("after_hard_mem", {25'd0, mem_config}, {25'd0, w7});
        chk("after_hard_comb", {27'd0, comb_config}, 32'h1f);

        // Reset mid-load, then loading restarts with the comb phase
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("midrst_comb", {27'd0, comb_config}, 32'd0);
        chk("midrst_mem", {25'd0, mem_config}, 32'd0);
        chk("midrst_so", {31'd0, shift_out}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            d[i] = 1'($urandom_range(0, 1));
            cycle(1'b0, 1'b0, 1'b0, d[i], 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) w5[4-i] = d[i];
        chk("restart_comb", {27'd0, comb_config}, {27'd0, w5});
        chk("restart_mem", {25'd0, mem_config}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom % 40) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #3;
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
